// File: rtl/fixed_point_dot_seq.sv
// Sequential signed fixed-point dot product: streams operand pairs from external
// memories, accumulates full-precision terms and saturates the sum once at the end.
module fixed_point_dot_seq #(
    parameter int DATA_WIDTH = 16,
    parameter int INTEGER    = 6,
    parameter int FRACTION   = 10,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] length,
    input  logic [DATA_WIDTH-1:0] bias,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] a_in,
    input  logic [DATA_WIDTH-1:0] b_in,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  overflow
);

    localparam int ACC_W = 2 * (INTEGER + FRACTION);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   len_q;
    logic signed [ACC_W-1:0] acc;
    logic                    vld_p1;

    logic signed [DATA_WIDTH-1:0] a_s, b_s, bias_s;
    logic signed [ACC_W-1:0]      a_ext, b_ext, bias_ext;
    logic signed [ACC_W-1:0]      prod_p1, term_p1, acc_sum_p1;
    logic [DATA_WIDTH:0]          sat_p1;

    // {overflow, clamped value}
    function automatic logic [DATA_WIDTH:0] saturate(input logic signed [ACC_W-1:0] x);
        if (x > SAT_MAX)
            return {1'b1, SAT_MAX[DATA_WIDTH-1:0]};
        else if (x < SAT_MIN)
            return {1'b1, SAT_MIN[DATA_WIDTH-1:0]};
        else
            return {1'b0, x[DATA_WIDTH-1:0]};
    endfunction

    // Stage p1: operands returned one cycle after rd_en; exact product, floor-truncated term
    assign a_s        = a_in;
    assign b_s        = b_in;
    assign bias_s     = bias;
    assign a_ext      = a_s;
    assign b_ext      = b_s;
    assign bias_ext   = bias_s;
    assign prod_p1    = a_ext * b_ext;
    assign term_p1    = prod_p1 >>> FRACTION;
    assign acc_sum_p1 = vld_p1 ? (acc + term_p1) : acc;
    assign sat_p1     = saturate(acc_sum_p1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            len_q    <= '0;
            acc      <= '0;
            vld_p1   <= 1'b0;
            rd_en    <= 1'b0;
            addr     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            vld_p1 <= rd_en;
            acc    <= acc_sum_p1;
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        len_q <= length;
                        acc   <= bias_ext;
                        addr  <= '0;
                        busy  <= 1'b1;
                        if (length == '0) begin
                            state    <= DONE;
                            done     <= 1'b1;
                            result   <= bias;
                            overflow <= 1'b0;
                        end else begin
                            state <= RUN;
                            rd_en <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (addr == len_q - ADDR_WIDTH'(1)) begin
                        state <= DRAIN;
                        rd_en <= 1'b0;
                        addr  <= '0;
                    end else begin
                        addr <= addr + ADDR_WIDTH'(1);
                    end
                end
                DRAIN: begin
                    state    <= DONE;
                    done     <= 1'b1;
                    result   <= sat_p1[DATA_WIDTH-1:0];
                    overflow <= sat_p1[DATA_WIDTH];
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    rd_en <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fixed_point_dot_seq.sv
// Directed bench for fixed_point_dot_seq with a one-cycle-latency operand memory model.
module tb_fixed_point_dot_seq;

    localparam int DW = 16;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] length;
    logic [DW-1:0] bias;
    logic          rd_en;
    logic [AW-1:0] addr;
    logic [DW-1:0] a_in, b_in;
    logic          busy, done, overflow;
    logic [DW-1:0] result;

    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] mem_b [32];

    int n_cmp = 0;
    int n_err = 0;

    int   done_cyc, rd_cnt, first_rd;
    logic addr_ok;

    fixed_point_dot_seq #(
        .DATA_WIDTH(DW), .INTEGER(6), .FRACTION(10), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .length(length), .bias(bias),
        .rd_en(rd_en), .addr(addr), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Operand memories: data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (rd_en) begin
            a_in <= mem_a[addr];
            b_in <= mem_b[addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic fill(input int n, input logic [DW-1:0] a, input logic [DW-1:0] b);
        for (int i = 0; i < n; i++) begin
            mem_a[i] = a;
            mem_b[i] = b;
        end
    endtask

    // Issues one start and watches the run; cycle 1 is the cycle after the sampling edge.
    task automatic run_op(input logic [AW-1:0] len, input logic [DW-1:0] bs, input bit poke);
        int extra;
        @(negedge clk);
        length = len;
        bias   = bs;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        done_cyc = 0;
        rd_cnt   = 0;
        first_rd = 0;
        addr_ok  = 1'b1;
        for (int c = 1; c <= 60 && done_cyc == 0; c++) begin
            if (c > 1) @(negedge clk);
            if (poke && c == 2) start = 1'b1;
            if (poke && c == 3) start = 1'b0;
            if (rd_en) begin
                if (first_rd == 0) first_rd = c;
                if (addr !== rd_cnt[AW-1:0]) addr_ok = 1'b0;
                rd_cnt++;
            end else if (addr !== '0) begin
                addr_ok = 1'b0;
            end
            if (done) done_cyc = c;
        end
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("idle_after_done", {31'd0, busy}, 32'd0);
        extra = 0;
        for (int c = 0; c < 4; c++) begin
            if (done) extra++;
            @(negedge clk);
        end
        chk("no_extra_done", extra, 0);
    endtask

    initial begin
        int saw_done;
        reset  = 1'b1;
        start  = 1'b0;
        length = '0;
        bias   = '0;
        for (int i = 0; i < 32; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("rst_result", {16'd0, result}, 32'd0);
        reset = 1'b0;

        // 1.0*1.5 + 2.0*1.5 - 0.5*1.5 = 3.75
        mem_a[0] = 16'h0400; mem_a[1] = 16'h0800; mem_a[2] = 16'hFE00;
        fill(0, '0, '0);
        for (int i = 0; i < 3; i++) mem_b[i] = 16'h0600;
        run_op(3, 16'h0000, 1'b0);
        chk("basic_done_cyc", done_cyc, 5);
        chk("basic_first_rd", first_rd, 1);
        chk("basic_rd_cnt", rd_cnt, 3);
        chk("basic_addr_seq", {31'd0, addr_ok}, 32'd1);
        chk("basic_result", {16'd0, result}, 32'h0F00);
        chk("basic_ovf", {31'd0, overflow}, 32'd0);

        // start pulses in RUN and in the DONE cycle are dropped
        run_op(3, 16'h0000, 1'b1);
        chk("poke_done_cyc", done_cyc, 5);
        chk("poke_rd_cnt", rd_cnt, 3);
        chk("poke_result", {16'd0, result}, 32'h0F00);

        fill(25, 16'h7FFF, 16'h7FFF);
        run_op(25, 16'h0000, 1'b0);
        chk("satpos_done_cyc", done_cyc, 27);
        chk("satpos_addr_seq", {31'd0, addr_ok}, 32'd1);
        chk("satpos_result", {16'd0, result}, 32'h7FFF);
        chk("satpos_ovf", {31'd0, overflow}, 32'd1);

        fill(25, 16'h8000, 16'h7FFF);
        run_op(25, 16'h0000, 1'b0);
        chk("satneg_result", {16'd0, result}, 32'h8000);
        chk("satneg_ovf", {31'd0, overflow}, 32'd1);

        // smallest positive times -1 floors to -1 LSB
        fill(1, 16'h0001, 16'hFFFF);
        run_op(1, 16'h0000, 1'b0);
        chk("floor_done_cyc", done_cyc, 3);
        chk("floor_result", {16'd0, result}, 32'h0000FFFF);
        chk("floor_ovf", {31'd0, overflow}, 32'd0);

        // -2.0 + 1.0*1.0 + 0.5*1.0 = -0.5
        mem_a[0] = 16'h0400; mem_a[1] = 16'h0200;
        mem_b[0] = 16'h0400; mem_b[1] = 16'h0400;
        run_op(2, 16'hF800, 1'b0);
        chk("bias_done_cyc", done_cyc, 4);
        chk("bias_result", {16'd0, result}, 32'h0000FE00);
        chk("bias_ovf", {31'd0, overflow}, 32'd0);

        run_op(0, 16'h0C00, 1'b0);
        chk("len0_done_cyc", done_cyc, 1);
        chk("len0_rd_cnt", rd_cnt, 0);
        chk("len0_result", {16'd0, result}, 32'h0C00);
        chk("len0_ovf", {31'd0, overflow}, 32'd0);

        // Reset in the middle of a run
        mem_a[0] = 16'h0400; mem_a[1] = 16'h0800; mem_a[2] = 16'hFE00;
        for (int i = 0; i < 3; i++) mem_b[i] = 16'h0600;
        @(negedge clk);
        length = 3;
        bias   = 16'h0000;
        start  = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 10 && !(rd_en && addr == 5'd1); c++) begin
            if (done) saw_done++;
            @(negedge clk);
        end
        chk("mid_addr1_reached", {27'd0, addr}, 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_rd_en", {31'd0, rd_en}, 32'd0);
        chk("mid_rst_addr", {27'd0, addr}, 32'd0);
        chk("mid_rst_result", {16'd0, result}, 32'd0);
        chk("mid_rst_ovf", {31'd0, overflow}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done) saw_done++;
        end
        chk("mid_no_done", saw_done, 0);
        reset = 1'b0;
        run_op(3, 16'h0000, 1'b0);
        chk("post_rst_done_cyc", done_cyc, 5);
        chk("post_rst_rd_cnt", rd_cnt, 3);
        chk("post_rst_result", {16'd0, result}, 32'h0F00);
        chk("post_rst_ovf", {31'd0, overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
